// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage core: arbitrates hazard/redirect requests into PC select,
// per-stage enables and flushes, squashes wrong-path fetches and keeps performance counters.
module pipeline_ctrl #(
    parameter int unsigned KILL_CYCLES = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall_i,
    input  logic             id_redirect_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    input  logic             wb_valid_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic [1:0]       pc_sel_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned KW = 3;

    localparam logic [1:0] SEL_PC4   = 2'd0;
    localparam logic [1:0] SEL_ID    = 2'd1;
    localparam logic [1:0] SEL_EX    = 2'd2;
    localparam logic [1:0] SEL_RESET = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_KILL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   kill_q, kill_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic            run_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_BOOT;
            kill_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            stall_q   <= stall_d;
        end
    end

    assign run_phase = (state_q != S_BOOT);

    // Request arbitration and sequencing; control outputs are same-cycle.
    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        pc_en_o       = 1'b1;
        pc_sel_o      = SEL_PC4;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_en_o    = 1'b1;
        id_ex_flush_o = 1'b0;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;

        if (rst) begin
            pc_en_o       = 1'b0;
            pc_sel_o      = SEL_RESET;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            ex_mem_en_o   = 1'b0;
            mem_wb_en_o   = 1'b0;
        end else if (state_q == S_BOOT) begin
            pc_sel_o      = SEL_RESET;
            if_id_flush_o = 1'b1;
            state_d       = S_RUN;
        end else begin
            if (mem_busy_i) begin
                pc_en_o     = 1'b0;
                if_id_en_o  = 1'b0;
                id_ex_en_o  = 1'b0;
                ex_mem_en_o = 1'b0;
                mem_wb_en_o = 1'b0;
            end else if (ex_redirect_i) begin
                pc_sel_o      = SEL_EX;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                if (KILL_CYCLES > 0) begin
                    state_d = S_KILL;
                    kill_d  = KW'(KILL_CYCLES);
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                // ID requests in KILL belong to wrong-path instructions.
                if (state_q == S_RUN && id_stall_i) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end else if (state_q == S_RUN && id_redirect_i) begin
                    pc_sel_o      = SEL_ID;
                    if_id_flush_o = 1'b1;
                end
                if (state_q == S_KILL) begin
                    kill_d = kill_q - KW'(1);
                    if (kill_q <= KW'(1)) begin
                        state_d = S_RUN;
                        kill_d  = '0;
                    end
                end
            end
            if (state_q == S_KILL) begin
                if_id_flush_o = 1'b1;
            end
        end
    end

    // Performance counters; clear wins over any increment.
    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        stall_d   = stall_q;
        if (cnt_clr_i) begin
            cycle_d   = '0;
            instret_d = '0;
            stall_d   = '0;
        end else begin
            if (run_phase) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (wb_valid_i && mem_wb_en_o) begin
                instret_d = instret_q + CNT_W'(1);
            end
            if (run_phase && !pc_en_o) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with KILL_CYCLES=2 and an 8-bit counter width for wrap checks.
module tb_pipeline_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_stall = 1'b0, id_redirect = 1'b0, ex_redirect = 1'b0;
    logic          mem_busy = 1'b0, wb_valid = 1'b0, cnt_clr = 1'b0;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0]    pc_sel;
    logic [CW-1:0] cycle_cnt, instret_cnt, stall_cnt;
    logic [8:0]    ctl;

    int n_vec = 0;
    int n_err = 0;

    // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [8:0] C_RST   = 9'b0_11_0_1_0_1_0_0;
    localparam logic [8:0] C_BOOT  = 9'b1_11_1_1_1_0_1_1;
    localparam logic [8:0] C_RUN   = 9'b1_00_1_0_1_0_1_1;
    localparam logic [8:0] C_STALL = 9'b0_00_0_0_1_1_1_1;
    localparam logic [8:0] C_EXR   = 9'b1_10_1_1_1_1_1_1;
    localparam logic [8:0] C_IDR   = 9'b1_01_1_1_1_0_1_1;
    localparam logic [8:0] C_KILL  = 9'b1_00_1_1_1_0_1_1;

    pipeline_ctrl #(.KILL_CYCLES(2), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_stall_i    (id_stall),
        .id_redirect_i (id_redirect),
        .ex_redirect_i (ex_redirect),
        .mem_busy_i    (mem_busy),
        .wb_valid_i    (wb_valid),
        .cnt_clr_i     (cnt_clr),
        .pc_en_o       (pc_en),
        .pc_sel_o      (pc_sel),
        .if_id_en_o    (if_id_en),
        .if_id_flush_o (if_id_flush),
        .id_ex_en_o    (id_ex_en),
        .id_ex_flush_o (id_ex_flush),
        .ex_mem_en_o   (ex_mem_en),
        .mem_wb_en_o   (mem_wb_en),
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

    // Inputs change 1ns after the edge; checks happen 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_vec++;
        if (ctl !== C_RST) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
        n_vec++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== 24'h0) begin
            n_err++; $display("FAIL reset_cnt: got %h/%h/%h want 0/0/0", cycle_cnt, instret_cnt, stall_cnt);
        end
        rst = 1'b0;
        settle();
        n_vec++;
        if (ctl !== C_BOOT) begin n_err++; $display("FAIL boot_ctl: got %b want %b", ctl, C_BOOT); end
        tick();
        n_vec++;
        if (ctl !== C_RUN) begin n_err++; $display("FAIL first_run_ctl: got %b want %b", ctl, C_RUN); end
        n_vec++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== 24'h0) begin
            n_err++; $display("FAIL first_run_cnt: got %h/%h/%h want 0/0/0", cycle_cnt, instret_cnt, stall_cnt);
        end
    endtask

    task automatic test_stall();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        id_stall = 1'b1;
        settle();
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL stall_c1: got %b want %b", ctl, C_STALL); end
        tick();
        settle();
        n_vec++;
        if (ctl !== C_STALL) begin n_err++; $display("FAIL stall_c2: got %b want %b", ctl, C_STALL); end
        tick();
        id_stall = 1'b0;
        settle();
        n_vec++;
        if (ctl !== C_RUN) begin n_err++; $display("FAIL stall_release: got %b want %b", ctl, C_RUN); end
        n_vec++;
        if (cycle_cnt !== 8'd2 || stall_cnt !== 8'd2 || instret_cnt !== 8'd0) begin
            n_err++; $display("FAIL stall_cnt: got c=%0d s=%0d r=%0d want c=2 s=2 r=0", cycle_cnt, stall_cnt, instret_cnt);
        end
    endtask

    task automatic test_redirect();
        ex_redirect = 1'b1; id_stall = 1'b1; id_redirect = 1'b1;
        settle();
        n_vec++;
        if (ctl !== C_EXR) begin n_err++; $display("FAIL exr_priority: got %b want %b", ctl, C_EXR); end
        tick();
        ex_redirect = 1'b0; id_stall = 1'b0;
        settle();
        n_vec++;
        if (ctl !== C_KILL) begin n_err++; $display("FAIL kill1_idr_ignored: got %b want %b", ctl, C_KILL); end
        tick();
        id_redirect = 1'b0; id_stall = 1'b1;
        settle();
        n_vec++;
        if (ctl !== C_KILL) begin n_err++; $display("FAIL kill2_stall_ignored: got %b want %b", ctl, C_KILL); end
        tick();
        id_stall = 1'b0; id_redirect = 1'b1;
        settle();
        n_vec++;
        if (ctl !== C_IDR) begin n_err++; $display("FAIL run_idr: got %b want %b", ctl, C_IDR); end
        tick();
        id_redirect = 1'b0;
        settle();
        n_vec++;
        if (ctl !== C_RUN) begin n_err++; $display("FAIL redirect_idle: got %b want %b", ctl, C_RUN); end
    endtask

    task automatic test_busy_kill();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wb_valid = 1'b1;
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++;
            if ({ctl[8:5], ctl[3:0]} !== 8'h00) begin
                n_err++; $display("FAIL busy_freeze[%0d]: got %b want enables 0, pc_sel 0", i, ctl);
            end
            tick();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if (ctl !== C_KILL) begin n_err++; $display("FAIL busy_kill_hold[%0d]: got %b want %b", i, ctl, C_KILL); end
            tick();
        end
        wb_valid = 1'b0;
        settle();
        n_vec++;
        if (ctl !== C_RUN) begin n_err++; $display("FAIL busy_kill_exit: got %b want %b", ctl, C_RUN); end
        n_vec++;
        if (cycle_cnt !== 8'd6 || instret_cnt !== 8'd3 || stall_cnt !== 8'd3) begin
            n_err++; $display("FAIL busy_cnt: got c=%0d r=%0d s=%0d want c=6 r=3 s=3", cycle_cnt, instret_cnt, stall_cnt);
        end
    endtask

    task automatic test_kill_reload();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        tick();
        ex_redirect = 1'b1;
        settle();
        n_vec++;
        if (ctl !== C_EXR) begin n_err++; $display("FAIL reload_exr: got %b want %b", ctl, C_EXR); end
        tick();
        ex_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if (ctl !== C_KILL) begin n_err++; $display("FAIL reload_kill[%0d]: got %b want %b", i, ctl, C_KILL); end
            tick();
        end
        settle();
        n_vec++;
        if (ctl !== C_RUN) begin n_err++; $display("FAIL reload_exit: got %b want %b", ctl, C_RUN); end
    endtask

    task automatic test_wrap();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wb_valid = 1'b1;
        repeat (255) tick();
        n_vec++;
        if (instret_cnt !== 8'hFF || cycle_cnt !== 8'hFF) begin
            n_err++; $display("FAIL wrap_full: got r=%h c=%h want r=ff c=ff", instret_cnt, cycle_cnt);
        end
        tick();
        n_vec++;
        if (instret_cnt !== 8'h00 || cycle_cnt !== 8'h00) begin
            n_err++; $display("FAIL wrap_zero: got r=%h c=%h want r=00 c=00", instret_cnt, cycle_cnt);
        end
        id_stall = 1'b1;
        tick();
        id_stall = 1'b0;
        tick();
        n_vec++;
        if (instret_cnt !== 8'd2 || cycle_cnt !== 8'd2 || stall_cnt !== 8'd1) begin
            n_err++; $display("FAIL pre_clr: got r=%0d c=%0d s=%0d want r=2 c=2 s=1", instret_cnt, cycle_cnt, stall_cnt);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wb_valid = 1'b0;
        settle();
        n_vec++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== 24'h0) begin
            n_err++; $display("FAIL clr_override: got %h/%h/%h want 0/0/0", cycle_cnt, instret_cnt, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_busy_kill();
        test_kill_reload();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core (IF, ID, EX, MEM, WB). It collects hazard and redirect requests from ID, EX, MEM and WB and drives PC select, per-stage pipeline-register enables and bubble (flush) controls. It also squashes wrong-path fetches after a redirect and keeps cycle, retire and stall performance counters readable through CSR.

Parameters:
KILL_CYCLES, 1, cycles IF/ID is flushed after an EX redirect to cover IMEM read latency (0..7).
CNT_W, 32, performance counter width.

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
id_stall  in  1  load-use stall request from ID decode
id_redirect  in  1  ID-resolved jump (JAL, or JALR with ready operand) target valid
ex_redirect  in  1  EX-resolved branch/JALR redirect (mispredict)
mem_busy  in  1  DMEM/IO not ready; freeze whole pipe
wb_valid  in  1  WB stage holds a real (non-bubble) instruction
cnt_clr  in  1  synchronous clear of all counters
pc_en  out  1  PC register load enable
pc_sel  out  2  0=PC+4, 1=ID target, 2=EX target, 3=reset vector
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads NOP
ex_mem_en  out  1  EX/MEM enable
mem_wb_en  out  1  MEM/WB enable
cycle_cnt  out  CNT_W  cycles since reset/clear
instret_cnt  out  CNT_W  retired instructions
stall_cnt  out  CNT_W  cycles with pc_en=0 outside BOOT

Behaviour:
- FSM states: BOOT, RUN, KILL. Reset (async) -> BOOT, kill_cnt=0, all counters=0.
- While rst high: all enables 0, both flushes 1, pc_sel=3.
- BOOT (exactly one cycle): pc_en=1, pc_sel=3, if_id_flush=1, other enables 1. Next state RUN. Requests are ignored in BOOT.
- Control outputs are combinational from state and requests (same-cycle). Counters are registered.
- Request priority, highest first, evaluated in RUN and KILL:
  1. mem_busy: every enable 0, no flush, pc_sel=0. State and kill_cnt hold. Lower requests stay pending; requesters keep them asserted.
  2. ex_redirect: pc_en=1, pc_sel=2, if_id_flush=1, id_ex_flush=1, all enables 1. If KILL_CYCLES>0, go to KILL with kill_cnt=KILL_CYCLES; otherwise stay in RUN. A redirect while in KILL reloads kill_cnt.
  3. id_stall: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  4. id_redirect: pc_en=1, pc_sel=1, if_id_flush=1, others 1.
  5. none: all enables 1, pc_sel=0, no flush.
- KILL: if_id_flush is forced to 1 in addition to the priority result. kill_cnt decrements on each cycle without mem_busy. At kill_cnt==1 with decrement, next state is RUN. An id_stall or id_redirect in KILL comes from a wrong-path instruction and is ignored.
- A flush takes precedence over the corresponding enable: the register loads NOP.
- Counters:
  - cycle_cnt increments every cycle outside BOOT.
  - instret_cnt increments when wb_valid && mem_wb_en.
  - stall_cnt increments when pc_en==0 outside BOOT.
  - All counters wrap modulo 2^CNT_W.
  - cnt_clr zeroes all counters the next edge and overrides any increment that cycle.

Test Plan:
- Reset release -> BOOT one cycle with pc_sel=3 and if_id_flush=1, then RUN with pc_sel=0 and all enables 1. Counters read 0 at the first RUN cycle.
- id_stall for 2 cycles in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 for both cycles. stall_cnt increases by 2; cycle_cnt increases by 2.
- ex_redirect with id_stall and id_redirect also high, KILL_CYCLES=2 -> pc_sel=2, both flushes asserted. Then 2 KILL cycles with if_id_flush=1, during which a concurrent id_redirect is ignored (pc_sel=0), then RUN.
- mem_busy for 3 cycles while in KILL with kill_cnt=2 -> all enables 0 for 3 cycles with kill_cnt held at 2. KILL then lasts 2 more cycles after mem_busy drops.
- ex_redirect in the second KILL cycle -> kill_cnt reloads to KILL_CYCLES and pc_sel=2.
- Preload instret_cnt=0xFFFFFFFF, then wb_valid=1 -> counter wraps to 0. Asserting cnt_clr together with wb_valid -> all counters read 0 the next cycle.
